// File: rtl/frame_buffer_planar_if.sv
// Arbiter write, video read, fill and page-swap signals of the planar frame buffer.
// master drives requests (arbiter / video side), slave is the frame buffer itself.
interface frame_buffer_planar_if #(
   parameter int unsigned PIXEL_W = 8,
   parameter int unsigned ADDR_W  = 17
);
   logic                arb_we;
   logic [ADDR_W-1:0]   arb_addr;
   logic [PIXEL_W-1:0]  arb_din;
   logic [PIXEL_W-1:0]  arb_mask;
   logic                arb_ready;

   logic                vga_re;
   logic [ADDR_W-1:0]   vga_addr;
   logic [PIXEL_W-1:0]  vga_dout;
   logic                vga_valid;

   logic                fill_start;
   logic [PIXEL_W-1:0]  fill_color;
   logic                fill_busy;
   logic                fill_done;

   logic                swap_req;
   logic                vsync;
   logic                front_page;

   modport master (
      output arb_we, arb_addr, arb_din, arb_mask,
      input  arb_ready,
      output vga_re, vga_addr,
      input  vga_dout, vga_valid,
      output fill_start, fill_color,
      input  fill_busy, fill_done,
      output swap_req, vsync,
      input  front_page
   );

   modport slave (
      input  arb_we, arb_addr, arb_din, arb_mask,
      output arb_ready,
      input  vga_re, vga_addr,
      output vga_dout, vga_valid,
      input  fill_start, fill_color,
      output fill_busy, fill_done,
      input  swap_req, vsync,
      output front_page
   );
endinterface

// File: rtl/frame_buffer_planar.sv
// Planar frame buffer: one 1-bit memory per pixel bit, masked arbiter writes, 2-cycle video read,
// whole-page fill engine. Define FRAME_BUFFER_DOUBLE_BUF_EN for a second page with vsync swapping.
module frame_buffer_planar #(
   parameter int unsigned PIXEL_W = 8,
   parameter int unsigned DEPTH   = 98304,
   parameter int unsigned ADDR_W  = 17
) (
   input logic                  clk,
   input logic                  rst,
   frame_buffer_planar_if.slave bus
);

`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
   localparam int unsigned PAGES = 2;
`else
   localparam int unsigned PAGES = 1;
`endif
   localparam int unsigned MEM_D = PAGES * DEPTH;
   localparam int unsigned IDX_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StFill = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  cnt_q;
   logic [PIXEL_W-1:0] color_q;
   logic               idle;

   assign idle = (state_q == StIdle);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.fill_start) state_d = StFill;
         StFill:  if (cnt_q == LAST) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         if (idle && bus.fill_start) begin
            color_q <= bus.fill_color;
            cnt_q   <= '0;
         end else if (state_q == StFill) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.arb_ready = idle;
   assign bus.fill_busy = !idle;
   assign bus.fill_done = (state_q == StDone);

   // Page selection: writes and fills go to the back page, video scans the front page.
   logic wr_page, rd_page;
`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
   logic front_q, pend_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         front_q <= 1'b0;
         pend_q  <= 1'b0;
      end else if (bus.vsync && (pend_q || bus.swap_req) && idle) begin
         front_q <= ~front_q;
         pend_q  <= 1'b0;
      end else begin
         pend_q <= pend_q | bus.swap_req;
      end
   end

   assign wr_page        = ~front_q;
   assign rd_page        = front_q;
   assign bus.front_page = front_q;
`else
   logic unused_swap;
   assign unused_swap    = bus.swap_req ^ bus.vsync;
   assign wr_page        = 1'b0;
   assign rd_page        = 1'b0;
   assign bus.front_page = 1'b0;
`endif

   logic               arb_wr, fill_wr, rd_inr;
   logic [PIXEL_W-1:0] wr_en, wr_data;
   logic [IDX_W-1:0]   wr_idx, rd_idx;

   // Reset blocks the write in its own cycle so an aborted fill stops exactly at its count.
   assign arb_wr  = !rst && idle && bus.arb_we && ({1'b0, bus.arb_addr} < DEPTH_X);
   assign fill_wr = !rst && (state_q == StFill);
   assign wr_en   = fill_wr ? '1 : (arb_wr ? bus.arb_mask : '0);
   assign wr_data = fill_wr ? color_q : bus.arb_din;
   assign wr_idx  = IDX_W'(fill_wr ? cnt_q : bus.arb_addr) + (wr_page ? IDX_W'(DEPTH) : '0);
   assign rd_idx  = IDX_W'(bus.vga_addr) + (rd_page ? IDX_W'(DEPTH) : '0);
   assign rd_inr  = ({1'b0, bus.vga_addr} < DEPTH_X);

   logic [PIXEL_W-1:0] mem_rd;

   for (genvar g = 0; g < PIXEL_W; g++) begin : g_plane
      logic plane [MEM_D];
      logic rd_bit_q;

      // Non-blocking read and write in one block gives read-first on collisions.
      always_ff @(posedge clk) begin
         if (wr_en[g]) plane[wr_idx] <= wr_data[g];
         rd_bit_q <= plane[rd_idx];
      end

      assign mem_rd[g] = rd_bit_q;
   end

   logic               rd_vld_q, rd_inr_q, vga_valid_q;
   logic [PIXEL_W-1:0] vga_dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q    <= 1'b0;
         rd_inr_q    <= 1'b0;
         vga_valid_q <= 1'b0;
         vga_dout_q  <= '0;
      end else begin
         rd_vld_q    <= bus.vga_re;
         rd_inr_q    <= rd_inr;
         vga_valid_q <= rd_vld_q;
         if (rd_vld_q) vga_dout_q <= rd_inr_q ? mem_rd : '0;
      end
   end

   assign bus.vga_valid = vga_valid_q;
   assign bus.vga_dout  = vga_dout_q;

endmodule

// File: tb/tb_frame_buffer_planar.sv
// Scoreboard bench for frame_buffer_planar with a reduced DEPTH; the page-swap sequence is
// selected when FRAME_BUFFER_DOUBLE_BUF_EN is defined.
module tb_frame_buffer_planar;
   localparam int unsigned PIXEL_W = 8;
   localparam int unsigned DEPTH   = 200;
   localparam int unsigned ADDR_W  = 8;

   typedef struct {
      logic [PIXEL_W-1:0] data;
      int                 cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   // Mid-fill stimulus hooks, -1 disables.
   int               ev_rd = -1, ev_wr = -1, ev_start = -1, ev_swap = -1, ev_vsync = -1;
   logic [PIXEL_W-1:0] ev_rd_exp = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   frame_buffer_planar_if #(.PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W)) bus ();

   frame_buffer_planar #(
      .PIXEL_W(PIXEL_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (bus.vga_valid) begin
         if (sb.size() == 0) begin
            check("rd_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data", 32'(bus.vga_dout), 32'(e.data));
            check("rd_latency", 32'(cyc - e.cyc), 32'd2);
         end
      end
   end

   task automatic clear_inputs();
      bus.arb_we = 1'b0; bus.vga_re = 1'b0; bus.fill_start = 1'b0;
      bus.swap_req = 1'b0; bus.vsync = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [PIXEL_W-1:0] d,
                     input logic [PIXEL_W-1:0] m);
      bus.arb_we = 1'b1; bus.arb_addr = a; bus.arb_din = d; bus.arb_mask = m;
      @(negedge clk);
      bus.arb_we = 1'b0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [PIXEL_W-1:0] exp);
      bus.vga_re = 1'b1; bus.vga_addr = a;
      sb.push_back('{exp, cyc});
      @(negedge clk);
      bus.vga_re = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic pulse_vsync();
      bus.vsync = 1'b1;
      @(negedge clk);
      bus.vsync = 1'b0;
   endtask

   task automatic do_fill(input logic [PIXEL_W-1:0] color);
      int busy_n = 0, done_n = 0, done_at = -1, rdy_bad = 0, i = 0;
      bus.fill_start = 1'b1; bus.fill_color = color;
      @(negedge clk);
      bus.fill_start = 1'b0;
      while (bus.fill_busy && i < int'(DEPTH) + 20) begin
         busy_n++;
         if (bus.fill_done) begin done_n++; done_at = i; end
         if (bus.arb_ready) rdy_bad++;
         bus.vga_re = (i == ev_rd);
         if (i == ev_rd) begin
            bus.vga_addr = ADDR_W'(DEPTH - 1);
            sb.push_back('{ev_rd_exp, cyc});
         end
         bus.arb_we = (i == ev_wr);
         bus.arb_addr = 8'd7; bus.arb_din = 8'hEE; bus.arb_mask = 8'hFF;
         bus.fill_start = (i == ev_start);
         if (i == ev_start) bus.fill_color = 8'h99;
         bus.swap_req = (i == ev_swap);
         bus.vsync = (i == ev_vsync);
         @(negedge clk);
         i++;
      end
      clear_inputs();
      check("fill_busy_len", 32'(busy_n), 32'(DEPTH + 1));
      check("fill_done_count", 32'(done_n), 32'd1);
      check("fill_done_at", 32'(done_at), 32'(DEPTH));
      check("fill_ready_low", 32'(rdy_bad), 32'd0);
      @(negedge clk);
      check("fill_no_restart", 32'(bus.fill_busy), 32'd0);
   endtask

   initial begin
      clear_inputs();
      bus.arb_addr = '0; bus.arb_din = '0; bus.arb_mask = '0;
      bus.vga_addr = '0; bus.fill_color = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_arb_ready", 32'(bus.arb_ready), 32'd1);
      check("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
      check("rst_vga_dout", 32'(bus.vga_dout), 32'd0);
      check("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
      check("rst_fill_done", 32'(bus.fill_done), 32'd0);
      check("rst_front_page", 32'(bus.front_page), 32'd0);
      rst = 1'b0;
      @(negedge clk);

`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
      wr(8'd3, 8'h55, 8'hFF);
      bus.swap_req = 1'b1;
      @(negedge clk);
      bus.swap_req = 1'b0;
      repeat (3) @(negedge clk);
      check("front_no_vsync", 32'(bus.front_page), 32'd0);
      pulse_vsync();
      check("front_after_vsync", 32'(bus.front_page), 32'd1);
      rd(8'd3, 8'h55);
      drain();
      ev_swap = 5; ev_vsync = 20;
      do_fill(8'h33);
      ev_swap = -1; ev_vsync = -1;
      check("front_deferred", 32'(bus.front_page), 32'd1);
      pulse_vsync();
      check("front_after_fill", 32'(bus.front_page), 32'd0);
      rd(8'd0, 8'h33);
      rd(ADDR_W'(DEPTH - 1), 8'h33);
      drain();
`else
      // Masked overwrite keeps the upper planes.
      wr(8'd5, 8'hA5, 8'hFF);
      wr(8'd5, 8'h00, 8'h0F);
      rd(8'd5, 8'hA0);
      drain();
      check("dout_hold", 32'(bus.vga_dout), 32'hA0);
      check("valid_low_idle", 32'(bus.vga_valid), 32'd0);

      wr(ADDR_W'(DEPTH - 1), 8'h3C, 8'hFF);
      wr(ADDR_W'(DEPTH), 8'h3C, 8'hFF);
      rd(ADDR_W'(DEPTH - 1), 8'h3C);
      rd(ADDR_W'(DEPTH), 8'h00);
      drain();

      ev_rd = 10; ev_rd_exp = 8'h3C; ev_wr = 60; ev_start = 50;
      do_fill(8'h11);
      ev_rd = -1; ev_wr = -1; ev_start = -1;
      rd(8'd0, 8'h11);
      rd(8'd100, 8'h11);
      rd(ADDR_W'(DEPTH - 1), 8'h11);
      rd(8'd7, 8'h11);
      drain();

      // Read-first on a same-address collision.
      wr(8'd9, 8'h22, 8'hFF);
      bus.arb_we = 1'b1; bus.arb_addr = 8'd9; bus.arb_din = 8'h77; bus.arb_mask = 8'hFF;
      bus.vga_re = 1'b1; bus.vga_addr = 8'd9;
      sb.push_back('{8'h22, cyc});
      @(negedge clk);
      clear_inputs();
      rd(8'd9, 8'h77);
      drain();

      // Reset while the fill counter sits at 100.
      wr(8'd150, 8'h42, 8'hFF);
      bus.fill_start = 1'b1; bus.fill_color = 8'h66;
      @(negedge clk);
      bus.fill_start = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.fill_busy), 32'd0);
      check("abort_ready", 32'(bus.arb_ready), 32'd1);
      begin
         int done_seen = int'(bus.fill_done);
         repeat (5) begin
            @(negedge clk);
            done_seen += int'(bus.fill_done);
         end
         check("abort_no_done", 32'(done_seen), 32'd0);
      end
      rd(8'd0, 8'h66);
      rd(8'd99, 8'h66);
      rd(8'd100, 8'h11);
      rd(8'd150, 8'h42);
      rd(ADDR_W'(DEPTH - 1), 8'h11);
      drain();

      bus.swap_req = 1'b1; bus.vsync = 1'b1;
      @(negedge clk);
      clear_inputs();
      check("front_single_page", 32'(bus.front_page), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/frame_buffer_planar.md
Name: frame_buffer_planar

Overview:
Parametrised single-clock planar frame buffer, successor to the fixed 8-plane × 98304-pixel buffer. Each pixel bit lives in its own memory plane. Per-plane write masking from the arbiter side and a registered, pipelined video read port. A hardware fill engine clears or paints the whole frame, and an optional second page supports tear-free double buffering. Sits between the memory arbiter (write side) and the VGA pixel fetch logic (read side).

Parameters:
PIXEL_W, 8, bits per pixel = number of memory planes
DEPTH, 98304, pixels per page
ADDR_W, 17, pixel address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  input  1  single clock for all logic and memories
rst  input  1  synchronous active-high reset
arb_we  input  1  arbiter write strobe
arb_addr  input  ADDR_W  arbiter pixel address
arb_din  input  PIXEL_W  write data, bit g goes to plane g
arb_mask  input  PIXEL_W  per-plane write enable; plane g written only if arb_mask[g]=1
arb_ready  output  1  write accepted this cycle when high
vga_re  input  1  video read request
vga_addr  input  ADDR_W  video pixel address
vga_dout  output  PIXEL_W  read pixel data
vga_valid  output  1  vga_dout holds data for the request issued 2 cycles earlier
fill_start  input  1  pulse: begin filling the write page
fill_color  input  PIXEL_W  fill value, sampled on the accepted fill_start cycle
fill_busy  output  1  fill engine active
fill_done  output  1  one-cycle pulse on fill completion
swap_req  input  1  request page swap (double-buffer only)
vsync  input  1  swap point, one-cycle pulse from video timing
front_page  output  1  page currently scanned out

Behaviour:
- Reset values: arb_ready=1, vga_dout=0, vga_valid=0, fill_busy=0, fill_done=0, front_page=0, swap pending cleared, FSM=IDLE, fill counter=0. Memory contents are not cleared by reset.
- Write: when arb_we && arb_ready && arb_addr<DEPTH, every plane g with arb_mask[g]=1 stores arb_din[g] at arb_addr. Writes to arb_addr>=DEPTH are accepted (ready high) and discarded.
- Read: 2-cycle latency.
  - Cycle 0: vga_re and vga_addr are sampled.
  - Cycle 1: memory output is produced.
  - Cycle 2: vga_dout and vga_valid are registered outputs.
  - vga_valid is vga_re delayed by 2.
  - A read of address >=DEPTH returns 0.
  - When vga_valid=0, vga_dout holds its last value.
- Read/write collision (same page, same address, same cycle): read returns the old data (read-first).
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE → FILL on fill_start. fill_color is latched and the counter is set to 0.
  - FILL: each cycle writes the latched colour to all planes at the counter address, then increments. At counter = DEPTH-1 the write occurs and the FSM goes to DONE. A fill takes exactly DEPTH cycles in FILL.
  - DONE: fill_done=1 for one cycle, then IDLE.
  - fill_busy=1 in FILL and DONE.
  - fill_start is ignored while fill_busy=1.
- arb_ready=0 whenever the FSM is not IDLE. The arbiter must hold its write until ready. Writes presented while arb_ready=0 are dropped.
- fill_start and arb_we in the same IDLE cycle: the arbiter write completes that cycle (arb_ready still 1); FILL begins next cycle and overwrites it.
- Video reads proceed unaffected during fills.
- rst mid-fill: returns to IDLE next cycle. A partial fill remains in memory; no fill_done pulse.

Optional Feature:
Macro FRAME_BUFFER_DOUBLE_BUF_EN.
- Defined: memory is 2×DEPTH per plane.
  - Arbiter writes and fills target page !front_page; video reads target front_page.
  - swap_req sets a pending flag. On the first vsync with the flag set, front_page toggles and the flag clears.
  - swap_req and vsync in the same cycle: the swap happens on that cycle's edge.
  - A swap is deferred (flag kept) while fill_busy=1, so a half-filled page is never displayed.
- Undefined: single page; front_page is constant 0; swap_req and vsync are ignored. Reads and writes share one page.

Test Plan:
- Write 0xA5 at addr 5 with mask 0xFF, then write 0x00 at addr 5 with mask 0x0F; read addr 5 → vga_dout=0xA0 with vga_valid exactly 2 cycles after vga_re.
- Write 0x3C at addr DEPTH-1 and at addr DEPTH; read both → 0x3C and 0x00 respectively.
- fill_start with fill_color=0x11 → fill_busy high for DEPTH+1 cycles, fill_done single pulse, arb_ready low throughout; reads of addr 0, 1000 and DEPTH-1 all return 0x11.
- Same-cycle write 0x77 and read at addr 9 (previously 0x22) → read returns 0x22; next read returns 0x77.
- Assert rst at fill count 100 → IDLE next cycle, no fill_done, arb_ready=1; addrs 0–99 hold the fill colour, addr 100 and above hold their prior data.
- FRAME_BUFFER_DOUBLE_BUF_EN defined:
  - Write 0x55 at addr 3 on the back page.
  - swap_req with no vsync → front_page stays 0.
  - Next vsync → front_page=1; read addr 3 → 0x55.
  - swap_req during a fill → swap is deferred until the first vsync after fill_done.
